// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared defaults and entry record for the store buffer
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 64;
  localparam int SB_DW = 64;
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match: youngest-entry address match search over the FIFO
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addrs [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0] head,
  input  logic [AW-1:0] addr,
  output logic hit,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] pos;
  // walk oldest to youngest so the last match found is the youngest
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PW'(k);
      if (valid[pos] && addrs[pos] == addr) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO store buffer with load forwarding and background drain
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CPU_WRITE,
  input  logic CPU_READ,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic [DW-1:0] CPU_RDATA,
  output logic STALL,
  output logic EMPTY,
  output logic MEM_WRITE,
  output logic MEM_READ,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] addrs [DEPTH];
  logic [DW-1:0] datas [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head, tail, idx;
  logic [PW:0] count;
  logic hit, full, enq, miss, drain;
  store_buffer_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
    .addrs(addrs),
    .valid(valid),
    .head(head),
    .addr(CPU_ADDR),
    .hit(hit),
    .idx(idx)
  );
  // a load miss owns the memory port, so draining waits
  always_comb begin
    full = count == (PW+1)'(DEPTH);
    enq = CPU_WRITE && !full;
    miss = CPU_READ && !hit;
    drain = count != '0 && !miss;
    STALL = CPU_WRITE && full;
    EMPTY = count == '0;
    MEM_READ = miss;
    MEM_WRITE = drain;
    MEM_ADDR = miss ? CPU_ADDR : drain ? addrs[head] : '0;
    MEM_WDATA = drain ? datas[head] : '0;
    CPU_RDATA = !CPU_READ ? '0 : hit ? datas[idx] : MEM_RDATA;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (enq) begin
        addrs[tail] <= CPU_ADDR;
        datas[tail] <= CPU_WDATA;
        valid[tail] <= 1'b1;
        tail <= tail + 1'b1;
      end
      if (drain) begin
        valid[head] <= 1'b0;
        head <= head + 1'b1;
      end
      count <= count + (PW+1)'(enq) - (PW+1)'(drain);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer
module tb_store_buffer;
  logic CLK = 1'b0;
  logic RESET, CPU_WRITE, CPU_READ;
  logic [63:0] CPU_ADDR, CPU_WDATA, CPU_RDATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic STALL, EMPTY, MEM_WRITE, MEM_READ;
  logic [63:0] mem [256];
  logic [63:0] wa [64];
  logic [63:0] wd [64];
  int wn = 0;
  int checks = 0;
  int errors = 0;
  int wn_saved;

  store_buffer dut (
    .CLK(CLK), .RESET(RESET), .CPU_WRITE(CPU_WRITE), .CPU_READ(CPU_READ),
    .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA), .CPU_RDATA(CPU_RDATA),
    .STALL(STALL), .EMPTY(EMPTY), .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  assign MEM_RDATA = mem[MEM_ADDR[7:0]];

  always @(posedge CLK) begin
    if (MEM_WRITE) begin
      mem[MEM_ADDR[7:0]] = MEM_WDATA;
      if (wn < 64) begin
        wa[wn] = MEM_ADDR;
        wd[wn] = MEM_WDATA;
      end
      wn = wn + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d);
    CPU_WRITE = w;
    CPU_READ = r;
    CPU_ADDR = a;
    CPU_WDATA = d;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 64'd5;
    RESET = 1'b1;
    drive(0, 0, 0, 0);
    step();
    step();
    RESET = 1'b0;
    #1;
    chk("rst_empty", 64'(EMPTY), 1);
    chk("rst_stall", 64'(STALL), 0);
    chk("rst_mwrite", 64'(MEM_WRITE), 0);
    chk("rst_mread", 64'(MEM_READ), 0);
    chk("rst_rdata", CPU_RDATA, 0);
    chk("rst_maddr", MEM_ADDR, 0);
    // store then forward
    drive(1, 0, 64'h10, 64'hAA);
    chk("st1_stall", 64'(STALL), 0);
    step();
    drive(0, 1, 64'h10, 0);
    chk("fwd_rdata", CPU_RDATA, 64'hAA);
    chk("fwd_mread", 64'(MEM_READ), 0);
    chk("fwd_drain_addr", MEM_ADDR, 64'h10);
    chk("fwd_drain_data", MEM_WDATA, 64'hAA);
    step();
    drive(0, 0, 0, 0);
    chk("fwd_empty", 64'(EMPTY), 1);
    chk("fwd_mem", mem[8'h10], 64'hAA);
    chk("idle_rdata", CPU_RDATA, 0);
    chk("idle_wdata", MEM_WDATA, 0);
    // duplicate address, youngest wins, drained in order
    drive(1, 0, 64'h8, 64'd1);
    step();
    drive(1, 0, 64'h8, 64'd2);
    chk("dup_drain1", MEM_WDATA, 64'd1);
    step();
    drive(0, 1, 64'h8, 0);
    chk("dup_rdata", CPU_RDATA, 64'd2);
    chk("dup_mread", 64'(MEM_READ), 0);
    step();
    drive(0, 0, 0, 0);
    chk("dup_wn", 64'(wn), 3);
    chk("dup_w1", wd[1], 64'd1);
    chk("dup_w2", wd[2], 64'd2);
    chk("dup_mem", mem[8], 64'd2);
    chk("dup_empty", 64'(EMPTY), 1);
    // fill under continuous misses
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 64'h20 + 64'(8 * i), 64'h11 * 64'(i + 1));
      chk("fill_miss", 64'(MEM_READ), 1);
      chk("fill_nowrite", 64'(MEM_WRITE), 0);
      step();
    end
    drive(1, 1, 64'h40, 64'h55);
    chk("full_stall", 64'(STALL), 1);
    chk("full_count", 64'(dut.count), 4);
    chk("full_nowrite", 64'(MEM_WRITE), 0);
    step();
    chk("full_hold_count", 64'(dut.count), 4);
    drive(1, 0, 64'h40, 64'h55);
    chk("full_norefill", 64'(STALL), 1);
    chk("resume_write", 64'(MEM_WRITE), 1);
    chk("resume_addr", MEM_ADDR, 64'h20);
    chk("resume_data", MEM_WDATA, 64'h11);
    step();
    chk("accept_stall", 64'(STALL), 0);
    step();
    drive(0, 0, 0, 0);
    chk("accept_count", 64'(dut.count), 3);
    step();
    chk("pre_miss_count", 64'(dut.count), 2);
    // load miss blocks drain
    drive(0, 1, 64'h0, 0);
    chk("miss_rdata", CPU_RDATA, 64'd5);
    chk("miss_mread", 64'(MEM_READ), 1);
    chk("miss_mwrite", 64'(MEM_WRITE), 0);
    chk("miss_maddr", MEM_ADDR, 64'h0);
    step();
    chk("miss_count", 64'(dut.count), 2);
    // reset discards pending stores
    drive(1, 1, 64'h48, 64'h66);
    step();
    chk("prerst_count", 64'(dut.count), 3);
    wn_saved = wn;
    RESET = 1'b1;
    drive(0, 1, 64'h80, 0);
    step();
    RESET = 1'b0;
    drive(0, 0, 0, 0);
    chk("rst2_empty", 64'(EMPTY), 1);
    chk("rst2_mwrite", 64'(MEM_WRITE), 0);
    step();
    step();
    chk("rst2_nowrites", 64'(wn), 64'(wn_saved));
    chk("rst2_mem48", mem[8'h48], 0);
    // simultaneous enqueue/drain with tail wrap
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 64'h50 + 64'(8 * i), 64'h70 + 64'(i));
      step();
    end
    drive(1, 0, 64'h68, 64'h73);
    chk("wrap_stall", 64'(STALL), 0);
    chk("wrap_mwrite", 64'(MEM_WRITE), 1);
    chk("wrap_pre_tail", 64'(dut.tail), 3);
    step();
    drive(0, 0, 0, 0);
    chk("wrap_count", 64'(dut.count), 3);
    chk("wrap_tail", 64'(dut.tail), 0);
    for (int i = 0; i < 4; i++) step();
    chk("wrap_empty", 64'(EMPTY), 1);
    chk("wrap_mem68", mem[8'h68], 64'h73);
    chk("wrap_mem50", mem[8'h50], 64'h70);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
